// File: rtl/seq_pattern_pkg.sv
// Shared encodings for the step-pattern controller: pattern modes, FSM states
// and the ODD4 break points where the step size changes.
package seq_pattern_pkg;

    typedef enum logic [1:0] {
        MODE_SEQ  = 2'd0,
        MODE_EVN  = 2'd1,
        MODE_ODD  = 2'd2,
        MODE_ODD4 = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam int ODD4_BREAK_LO = 7;
    localparam int ODD4_BREAK_HI = 8;

endpackage

// File: rtl/seq_base_step.sv
// Combinational next-base computation for the outer base register. The result
// is one bit wider than the base so an overshoot past the top never wraps.
module seq_base_step
    import seq_pattern_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  mode_e              mode,
    input  logic [WIDTH-1:0]   base,
    output logic [WIDTH:0]     next_base
);

    logic [1:0] step;

    always_comb begin
        step = 2'd2;
        case (mode)
            MODE_SEQ:  step = 2'd1;
            MODE_EVN:  step = 2'd2;
            MODE_ODD:  step = (base == '0) ? 2'd1 : 2'd2;
            MODE_ODD4: begin
                if (base == '0 || int'(base) == ODD4_BREAK_LO)
                    step = 2'd1;
                else if (int'(base) == ODD4_BREAK_HI)
                    step = 2'd3;
                else
                    step = 2'd2;
            end
            default:   step = 2'd2;
        endcase
    end

    assign next_base = {1'b0, base} + {{(WIDTH-1){1'b0}}, step};

endmodule

// File: rtl/seq_pattern_ctrl.sv
// Runtime-configurable sequencer for the base/sweep pattern stream with
// start/stop control, a valid/ready output handshake and pass counting.
module seq_pattern_ctrl
    import seq_pattern_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int PW    = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] limit,
    input  logic [PW-1:0]    passes,
    input  logic             ready,
    output logic [WIDTH-1:0] seq_out,
    output logic             seq_valid,
    output logic             busy,
    output logic             done,
    output logic [PW-1:0]    pass_cnt
);

    state_e           state_q;
    mode_e            mode_q;
    logic [WIDTH-1:0] limit_q;
    logic [PW-1:0]    passes_q;
    logic [WIDTH-1:0] base_q;
    logic [WIDTH-1:0] count_q;
    logic [PW-1:0]    pass_cnt_q;

    logic [WIDTH:0]   base_d;
    logic [PW-1:0]    pass_cnt_d;

    seq_base_step #(.WIDTH(WIDTH)) u_step (
        .mode      (mode_q),
        .base      (base_q),
        .next_base (base_d)
    );

    assign pass_cnt_d = pass_cnt_q + 1'b1;

    // Stop has priority over everything in RUN, including an accepted beat.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            mode_q     <= MODE_SEQ;
            limit_q    <= '0;
            passes_q   <= '0;
            base_q     <= '0;
            count_q    <= '0;
            pass_cnt_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start && !stop) begin
                        mode_q     <= mode_e'(mode);
                        limit_q    <= limit;
                        passes_q   <= passes;
                        base_q     <= '0;
                        count_q    <= '0;
                        pass_cnt_q <= '0;
                        state_q    <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (stop) begin
                        state_q <= ST_IDLE;
                    end else if (ready) begin
                        if (count_q < limit_q) begin
                            count_q <= count_q + 1'b1;
                        end else if (base_d <= {1'b0, limit_q}) begin
                            base_q  <= base_d[WIDTH-1:0];
                            count_q <= base_d[WIDTH-1:0];
                        end else begin
                            pass_cnt_q <= pass_cnt_d;
                            if (passes_q != '0 && pass_cnt_d == passes_q) begin
                                state_q <= ST_DONE;
                            end else begin
                                base_q  <= '0;
                                count_q <= '0;
                            end
                        end
                    end
                end
                ST_DONE: state_q <= ST_IDLE;
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign busy      = (state_q == ST_RUN);
    assign seq_valid = (state_q == ST_RUN);
    assign done      = (state_q == ST_DONE);
    assign seq_out   = (state_q == ST_RUN) ? count_q : '0;
    assign pass_cnt  = pass_cnt_q;

endmodule

// File: tb/tb_seq_pattern_ctrl.sv
// Self-checking bench for seq_pattern_ctrl: a pass-list reference model builds
// the expected beat stream and the DUT is driven with random ready/start noise.
module tb_seq_pattern_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic [1:0] mode = 2'd0;
    logic [3:0] limit = 4'd0;
    logic [3:0] passes = 4'd0;
    logic       ready = 1'b0;
    logic [3:0] seq_out;
    logic       seq_valid;
    logic       busy;
    logic       done;
    logic [3:0] pass_cnt;

    int nChecks = 0;
    int nFail = 0;

    seq_pattern_ctrl #(.WIDTH(4), .PW(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .stop      (stop),
        .mode      (mode),
        .limit     (limit),
        .passes    (passes),
        .ready     (ready),
        .seq_out   (seq_out),
        .seq_valid (seq_valid),
        .busy      (busy),
        .done      (done),
        .pass_cnt  (pass_cnt)
    );

    always #5 clk = ~clk;

    // Step size for the outer base as a function of mode and current base.
    function automatic int stepOf(int m, int b);
        case (m)
            0:       return 1;
            1:       return 2;
            2:       return (b == 0) ? 1 : 2;
            default: return (b == 0 || b == 7) ? 1 : ((b == 8) ? 3 : 2);
        endcase
    endfunction

    task automatic checkOutput(string tag, logic [31:0] observed, logic [31:0] expected);
        nChecks++;
        assert (observed === expected)
        else begin
            nFail++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // One run: build the expected stream, start the DUT, consume beats and
    // check either the done pulse or (when stopAfter>=0) a clean abort.
    task automatic applyStimulus(int m, int lim, int pss, int modelPasses,
                                 int stopAfter, bit alwaysReady);
        int expQ[$];
        int passQ[$];
        int accepted;
        int cycles;
        int b;
        bit more;
        bit stopped;
        accepted = 0;
        cycles = 0;
        stopped = 1'b0;
        for (int p = 0; p < modelPasses; p++) begin
            b = 0;
            more = 1'b1;
            while (more) begin
                for (int c = b; c <= lim; c++) begin
                    expQ.push_back(c);
                    passQ.push_back(p % 16);
                end
                b = b + stepOf(m, b);
                if (b > lim) more = 1'b0;
            end
        end

        @(negedge clk);
        mode = m[1:0];
        limit = lim[3:0];
        passes = pss[3:0];
        start = 1'b1;
        stop = 1'b0;
        ready = 1'b0;

        while (expQ.size() > 0) begin
            @(negedge clk);
            cycles++;
            start = ($urandom_range(0, 7) == 0);
            checkOutput("seq_valid", seq_valid, 1);
            checkOutput("busy", busy, 1);
            checkOutput("done_in_run", done, 0);
            checkOutput("seq_out", seq_out, expQ[0]);
            checkOutput("pass_cnt_run", pass_cnt, passQ[0]);
            if (accepted == stopAfter) begin
                start = 1'b0;
                stop = 1'b1;
                ready = $urandom_range(0, 1);
                stopped = 1'b1;
                break;
            end
            ready = alwaysReady ? 1'b1 : ($urandom_range(0, 3) != 0);
            if (ready) begin
                void'(expQ.pop_front());
                void'(passQ.pop_front());
                accepted++;
            end
            if (cycles > 3000) begin
                nChecks++;
                nFail++;
                $display("[TB] FAIL timeout observed=%0d_cycles expected=stream_end", cycles);
                break;
            end
        end

        @(negedge clk);
        start = 1'b0;
        stop = 1'b0;
        ready = 1'b0;
        if (stopped) begin
            checkOutput("stop_valid", seq_valid, 0);
            checkOutput("stop_busy", busy, 0);
            checkOutput("stop_no_done", done, 0);
        end else begin
            checkOutput("done_pulse", done, 1);
            checkOutput("done_valid", seq_valid, 0);
            checkOutput("done_busy", busy, 0);
            checkOutput("done_pass_cnt", pass_cnt, pss);
            @(negedge clk);
            checkOutput("done_one_cycle", done, 0);
            checkOutput("idle_busy", busy, 0);
            checkOutput("idle_pass_cnt", pass_cnt, pss);
        end
    endtask

    initial begin
        #12;
        checkOutput("reset_valid", seq_valid, 0);
        checkOutput("reset_busy", busy, 0);
        checkOutput("reset_done", done, 0);
        checkOutput("reset_seq_out", seq_out, 0);
        checkOutput("reset_pass_cnt", pass_cnt, 0);
        @(negedge clk);
        rst = 1'b0;

        // start and stop together: stop wins, DUT stays idle
        @(negedge clk);
        start = 1'b1;
        stop = 1'b1;
        @(negedge clk);
        start = 1'b0;
        stop = 1'b0;
        checkOutput("start_stop_busy", busy, 0);
        checkOutput("start_stop_valid", seq_valid, 0);

        applyStimulus(0, 3, 1, 1, -1, 1'b1);
        applyStimulus(1, 5, 1, 1, -1, 1'b1);
        applyStimulus(2, 4, 1, 1, -1, 1'b1);
        applyStimulus(3, 15, 1, 1, -1, 1'b0);
        applyStimulus(0, 2, 1, 1, -1, 1'b0);
        applyStimulus(0, 0, 1, 1, -1, 1'b0);
        applyStimulus(0, 1, 2, 2, -1, 1'b0);
        applyStimulus(0, 0, 0, 18, 17, 1'b0);
        applyStimulus(1, 15, 1, 1, -1, 1'b0);
        applyStimulus(0, 4, 1, 1, 3, 1'b0);

        // asynchronous reset mid-run with a non-zero pass count
        @(negedge clk);
        mode = 2'd0;
        limit = 4'd0;
        passes = 4'd3;
        start = 1'b1;
        ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("async_rst_valid", seq_valid, 0);
        checkOutput("async_rst_busy", busy, 0);
        checkOutput("async_rst_seq_out", seq_out, 0);
        checkOutput("async_rst_pass_cnt", pass_cnt, 0);
        checkOutput("async_rst_done", done, 0);
        @(negedge clk);
        rst = 1'b0;
        ready = 1'b0;
        applyStimulus(0, 3, 1, 1, -1, 1'b0);

        for (int r = 0; r < 6; r++) begin
            int rm;
            int rl;
            int rp;
            rm = $urandom_range(0, 3);
            rl = $urandom_range(0, 15);
            rp = $urandom_range(1, 3);
            applyStimulus(rm, rl, rp, rp, -1, 1'b0);
        end
        applyStimulus(3, 12, 2, 2, 9, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end

endmodule
